// File: rtl/iir_biquad_cascade_slow.sv
// iir_biquad_cascade_slow: time-multiplexed cascade of biquad sections on one shared 35x35 MAC.
// Output clamping is enabled by defining IIR_BIQUAD_SATURATE_EN; otherwise stage outputs wrap.
module iir_biquad_cascade_slow #(
  parameter int N_STAGES        = 2,
  parameter int SIGNAL_IN_SIZE  = 16,
  parameter int SIGNAL_OUT_SIZE = 16,
  parameter int A0_SHIFT        = 32,
  parameter int N_WAIT          = 4
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              on_in,
  input  logic                              sample_valid_in,
  input  logic signed [SIGNAL_IN_SIZE-1:0]  signal_in,
  input  logic                              coef_we,
  input  logic [5:0]                        coef_addr,
  input  logic signed [34:0]                coef_data,
  input  logic                              coef_commit,
  output logic                              busy_out,
  output logic                              out_valid,
  output logic signed [SIGNAL_OUT_SIZE-1:0] signal_out,
  output logic                              overrun_out
);
  localparam int NC = 5 * N_STAGES;
  localparam int AW = $clog2(NC);
  localparam int SW = N_STAGES > 1 ? $clog2(N_STAGES) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, MAC_A, MAC_B, STORE, DONE} state_t;
  state_t state;
  logic signed [34:0] shadow [NC];
  logic signed [34:0] active [NC];
  logic signed [31:0] x_in [N_STAGES];
  logic signed [31:0] x1 [N_STAGES];
  logic signed [31:0] x2 [N_STAGES];
  logic signed [31:0] y1 [N_STAGES];
  logic signed [31:0] y2 [N_STAGES];
  logic [3:0] stage, wcnt;
  logic [2:0] tap;
  logic pending;
  logic signed [34:0] mul_a, mul_b;
  logic signed [69:0] acc, acc_base, prod;
  logic signed [31:0] opnd, y_red, in_al;
  logic [SW-1:0] si;
  logic [AW-1:0] cidx;
`ifdef IIR_BIQUAD_SATURATE_EN
  localparam logic signed [69:0] Y_MAX = 70'sd2147483647;
  localparam logic signed [69:0] Y_MIN = -70'sd2147483648;
  logic signed [69:0] y_full;
`endif
  always_comb begin
    in_al = 32'(signal_in) <<< (32 - SIGNAL_IN_SIZE);
    si = stage[SW-1:0];
    cidx = AW'(6'(stage) * 6'd5 + 6'(tap));
    opnd = tap == 3'd0 ? x_in[si] : tap == 3'd1 ? x1[si] : tap == 3'd2 ? x2[si] :
           tap == 3'd3 ? y1[si] : y2[si];
    // operands are held for the whole MAC_B window, so the product may settle over N_WAIT cycles
    prod = $signed({{35{mul_a[34]}}, mul_a} * {{35{mul_b[34]}}, mul_b});
`ifdef IIR_BIQUAD_SATURATE_EN
    y_full = acc >>> A0_SHIFT;
    y_red = y_full > Y_MAX ? 32'sh7FFFFFFF : y_full < Y_MIN ? 32'sh80000000 : y_full[31:0];
`else
    y_red = 32'(acc >>> A0_SHIFT);
`endif
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      stage <= '0;
      tap <= '0;
      wcnt <= '0;
      pending <= 1'b0;
      acc <= '0;
      acc_base <= '0;
      mul_a <= '0;
      mul_b <= '0;
      busy_out <= 1'b0;
      out_valid <= 1'b0;
      signal_out <= '0;
      overrun_out <= 1'b0;
      for (int i = 0; i < NC; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      for (int i = 0; i < N_STAGES; i++) begin
        x_in[i] <= '0;
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else begin
      if (coef_we && coef_addr < 6'(NC)) shadow[coef_addr[AW-1:0]] <= coef_data;
      // the bank only swaps between computations so one sample never mixes coefficient sets
      if (state == IDLE && (pending || coef_commit)) begin
        active <= shadow;
        pending <= 1'b0;
      end else if (coef_commit) pending <= 1'b1;
      if (!on_in) begin
        state <= IDLE;
        busy_out <= 1'b0;
        overrun_out <= 1'b0;
        out_valid <= sample_valid_in;
        signal_out <= in_al[31 -: SIGNAL_OUT_SIZE];
        acc <= '0;
        for (int i = 0; i < N_STAGES; i++) begin
          x_in[i] <= '0;
          x1[i] <= '0;
          x2[i] <= '0;
          y1[i] <= '0;
          y2[i] <= '0;
        end
      end else begin
        out_valid <= 1'b0;
        if (sample_valid_in && state != IDLE) overrun_out <= 1'b1;
        case (state)
          IDLE: if (sample_valid_in) begin
            state <= LOAD;
            busy_out <= 1'b1;
            x_in[0] <= in_al;
          end
          LOAD: begin
            stage <= '0;
            tap <= '0;
            acc <= '0;
            state <= MAC_A;
          end
          MAC_A: begin
            mul_a <= active[cidx];
            mul_b <= 35'(opnd);
            acc_base <= acc;
            wcnt <= '0;
            state <= MAC_B;
          end
          MAC_B: begin
            acc <= acc_base + prod;
            wcnt <= wcnt + 4'd1;
            if (wcnt == 4'(N_WAIT - 1)) begin
              tap <= tap == 3'd4 ? 3'd0 : tap + 3'd1;
              state <= tap == 3'd4 ? STORE : MAC_A;
            end
          end
          STORE: begin
            x1[si] <= x_in[si];
            x2[si] <= x1[si];
            y1[si] <= y_red;
            y2[si] <= y1[si];
            acc <= '0;
            if (stage == 4'(N_STAGES - 1)) begin
              state <= DONE;
              out_valid <= 1'b1;
              signal_out <= y_red[31 -: SIGNAL_OUT_SIZE];
            end else begin
              x_in[si + 1'b1] <= y_red;
              stage <= stage + 4'd1;
              state <= MAC_A;
            end
          end
          DONE: begin
            state <= IDLE;
            busy_out <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_iir_biquad_cascade_slow.sv
// tb_iir_biquad_cascade_slow: directed plus randomized checks against an arithmetic biquad cascade model.
module tb_iir_biquad_cascade_slow;
  logic clk_in = 1'b0;
  logic rst_in, on_in, sample_valid_in, coef_we, coef_commit;
  logic [15:0] signal_in;
  logic [5:0] coef_addr;
  logic [34:0] coef_data;
  logic busy_out, out_valid, overrun_out;
  logic [15:0] signal_out;
  int n_tests = 0, n_fail = 0;
  logic signed [34:0] msh [10];
  logic signed [34:0] mact [10];
  logic signed [31:0] mx1 [2], mx2 [2], my1 [2], my2 [2];
  localparam logic signed [34:0] UNITY = 35'sh1_0000_0000;
  always #5 clk_in = ~clk_in;
  iir_biquad_cascade_slow dut (
    .clk_in(clk_in), .rst_in(rst_in), .on_in(on_in), .sample_valid_in(sample_valid_in),
    .signal_in(signal_in), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_commit(coef_commit), .busy_out(busy_out), .out_valid(out_valid),
    .signal_out(signal_out), .overrun_out(overrun_out)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void clear_hist();
    for (int s = 0; s < 2; s++) begin
      mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
    end
  endfunction
  // y = (b0*x + b1*x[n-1] + b2*x[n-2] + a1*y[n-1] + a2*y[n-2]) / 2^32, per stage, wide exact arithmetic
  function automatic logic [31:0] model_step(input logic signed [31:0] xin);
    logic signed [127:0] sum, c, d [5];
    logic signed [31:0] x, y;
    x = xin;
    for (int s = 0; s < 2; s++) begin
      d[0] = x; d[1] = mx1[s]; d[2] = mx2[s]; d[3] = my1[s]; d[4] = my2[s];
      sum = 0;
      for (int k = 0; k < 5; k++) begin
        c = mact[s * 5 + k];
        sum = sum + c * d[k];
      end
      sum = sum >>> 32;
`ifdef IIR_BIQUAD_SATURATE_EN
      if (sum > 128'sd2147483647) y = 32'sh7FFFFFFF;
      else if (sum < -128'sd2147483648) y = 32'sh80000000;
      else y = sum[31:0];
`else
      y = sum[31:0];
`endif
      mx2[s] = mx1[s]; mx1[s] = x; my2[s] = my1[s]; my1[s] = y;
      x = y;
    end
    return x;
  endfunction
  task automatic wr_coef(input int addr, input logic [34:0] data);
    @(negedge clk_in);
    coef_we = 1'b1; coef_addr = 6'(addr); coef_data = data;
    @(negedge clk_in);
    coef_we = 1'b0;
    if (addr < 10) msh[addr] = data;
  endtask
  task automatic set_stage(input int s, input logic [34:0] b0, b1, b2, a1, a2);
    wr_coef(s * 5, b0); wr_coef(s * 5 + 1, b1); wr_coef(s * 5 + 2, b2);
    wr_coef(s * 5 + 3, a1); wr_coef(s * 5 + 4, a2);
  endtask
  task automatic do_commit();
    @(negedge clk_in); coef_commit = 1'b1;
    @(negedge clk_in); coef_commit = 1'b0;
    mact = msh;
  endtask
  task automatic do_reset();
    @(negedge clk_in); rst_in = 1'b1;
    @(negedge clk_in); @(negedge clk_in); rst_in = 1'b0;
    clear_hist();
    for (int i = 0; i < 10; i++) begin msh[i] = 0; mact[i] = 0; end
  endtask
  // mode 1 injects a second strobe mid-run, mode 2 rewrites b0 and commits mid-run
  task automatic do_sample(input string tag, input logic [15:0] x, input int mode, output logic [15:0] got);
    logic [31:0] ym;
    logic [15:0] exp;
    int cnt;
    ym = model_step({x, 16'h0});
    exp = ym[31:16];
    @(negedge clk_in); signal_in = x; sample_valid_in = 1'b1;
    @(negedge clk_in); sample_valid_in = 1'b0; cnt = 1;
    check({tag, "_busy"}, 32'(busy_out), 1);
    while (!out_valid && cnt < 200) begin
      if (mode == 1 && cnt == 10) begin sample_valid_in = 1'b1; signal_in = 16'h7777; end
      if (mode == 1 && cnt == 11) sample_valid_in = 1'b0;
      if (mode == 2 && cnt == 10) begin
        coef_we = 1'b1; coef_addr = 6'd0; coef_data = 35'h0_8000_0000; msh[0] = 35'sh0_8000_0000;
      end
      if (mode == 2 && cnt == 11) begin coef_we = 1'b0; coef_commit = 1'b1; end
      if (mode == 2 && cnt == 12) coef_commit = 1'b0;
      @(negedge clk_in); cnt++;
    end
    check({tag, "_lat"}, 32'(cnt), 54);
    check({tag, "_y"}, 32'(signal_out), 32'(exp));
    got = signal_out;
    @(negedge clk_in);
    check({tag, "_idle"}, {30'd0, out_valid, busy_out}, 0);
    if (mode == 2) mact = msh;
  endtask
  initial begin
    logic [15:0] got, r;
    logic [63:0] t;
    int seen;
    rst_in = 1'b1; on_in = 1'b1; sample_valid_in = 1'b0; signal_in = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; coef_commit = 1'b0;
    clear_hist();
    for (int i = 0; i < 10; i++) begin msh[i] = 0; mact[i] = 0; end
    repeat (3) @(negedge clk_in);
    check("rst_y", 32'(signal_out), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy_out), 0);
    check("rst_ovr", 32'(overrun_out), 0);
    rst_in = 1'b0;
    on_in = 1'b0; r = 16'($urandom); signal_in = r; sample_valid_in = 1'b1;
    @(negedge clk_in); sample_valid_in = 1'b0;
    check("byp_y", 32'(signal_out), 32'(r));
    check("byp_valid", 32'(out_valid), 1);
    @(negedge clk_in);
    check("byp_valid_end", 32'(out_valid), 0);
    on_in = 1'b1; clear_hist();
    set_stage(0, UNITY, 0, 0, 0, 0);
    set_stage(1, UNITY, 0, 0, 0, 0);
    do_commit();
    do_sample("unity", 16'h1234, 0, got);
    check("unity_val", 32'(got), 32'h1234);
    do_sample("ovr", 16'h1234, 1, got);
    check("ovr_first", 32'(got), 32'h1234);
    check("ovr_set", 32'(overrun_out), 1);
    seen = 0;
    repeat (60) begin @(negedge clk_in); if (out_valid) seen++; end
    check("ovr_drop", 32'(seen), 0);
    check("ovr_sticky", 32'(overrun_out), 1);
    @(negedge clk_in); on_in = 1'b0;
    @(negedge clk_in); on_in = 1'b1; clear_hist();
    check("ovr_clr", 32'(overrun_out), 0);
    do_sample("commit_old", 16'h1234, 2, got);
    check("commit_old_val", 32'(got), 32'h1234);
    do_sample("commit_new", 16'h1234, 0, got);
    check("commit_new_val", 32'(got), 32'h091A);
    wr_coef(0, 35'h3_FFFF_FFFF);
    do_commit();
    do_sample("sat", 16'h4000, 0, got);
`ifdef IIR_BIQUAD_SATURATE_EN
    check("sat_val", 32'(got), 32'h7FFF);
`else
    check("sat_val", 32'(got), 32'hFFFF);
`endif
    @(negedge clk_in); signal_in = 16'h1234; sample_valid_in = 1'b1;
    @(negedge clk_in); sample_valid_in = 1'b0;
    repeat (19) @(negedge clk_in);
    on_in = 1'b0; signal_in = 16'h2345;
    @(negedge clk_in);
    check("abort_busy", 32'(busy_out), 0);
    check("abort_byp", 32'(signal_out), 32'h2345);
    signal_in = 16'h5AA5;
    @(negedge clk_in);
    check("abort_follow", 32'(signal_out), 32'h5AA5);
    seen = 0;
    repeat (60) begin @(negedge clk_in); if (out_valid) seen++; end
    check("abort_novalid", 32'(seen), 0);
    on_in = 1'b1; clear_hist();
    @(negedge clk_in); signal_in = 16'h1234; sample_valid_in = 1'b1;
    @(negedge clk_in); sample_valid_in = 1'b0;
    repeat (19) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("mrst_out", {15'd0, signal_out, out_valid}, 0);
    check("mrst_flags", {30'd0, busy_out, overrun_out}, 0);
    rst_in = 1'b0;
    clear_hist();
    for (int i = 0; i < 10; i++) begin msh[i] = 0; mact[i] = 0; end
    do_sample("zero_coef", 16'h1234, 0, got);
    check("zero_coef_val", 32'(got), 0);
    set_stage(0, UNITY, 0, 0, 35'h0_8000_0000, 0);
    set_stage(1, UNITY, 0, 0, 0, 0);
    do_commit();
    do_sample("imp0", 16'h1000, 0, got); check("imp0_val", 32'(got), 32'h1000);
    do_sample("imp1", 16'h0000, 0, got); check("imp1_val", 32'(got), 32'h0800);
    do_sample("imp2", 16'h0000, 0, got); check("imp2_val", 32'(got), 32'h0400);
    do_sample("imp3", 16'h0000, 0, got); check("imp3_val", 32'(got), 32'h0200);
    for (int round = 0; round < 3; round++) begin
      for (int k = 0; k < 10; k++) begin
        t = {$urandom, $urandom};
        wr_coef(k, t[34:0]);
      end
      t = {$urandom, $urandom};
      wr_coef(int'($urandom_range(10, 63)), t[34:0]);
      do_commit();
      for (int n = 0; n < 6; n++) do_sample("rnd", 16'($urandom), 0, got);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
